cdc_event_scheduler: RTL and testbench

- Shares one stretched-pulse clock-domain-crossing flag channel among NUM_REQ single-cycle event sources in the source clock domain.
- Latches each event as pending and grants pending events round-robin.
- Per grant: emits a one-cycle flag pulse plus a stable event ID, then enforces a holdoff so consecutive pulses stay distinct after the crossing stretches them by 8 cycles and synchronises them.
- Sits between the source-domain event generators and the flag-crossing instance; id_out is held stable for the destination domain to sample.

---
 rtl/cdc_event_scheduler.sv | 161 ++++++++++++++++
 tb/tb_cdc_event_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_event_scheduler.sv
// -----------------------------------------------------------------------------
// cdc_event_scheduler
//
// Shares one stretched-pulse flag crossing among NUM_REQ single-cycle event
// sources that all live in the source clock domain.
//
// Each incoming event is latched as pending. Pending events are granted in
// round-robin order. A grant emits a one-cycle flag pulse together with a
// stable event ID. After each grant the block waits out a holdoff window.
// The window is long enough that the crossing's 8-cycle stretch, plus the
// destination synchroniser, sees every pulse as a separate event.
//
// Ports
//   clk          : source-domain clock
//   reset_n      : asynchronous, active-low reset
//   enable       : 1 allows new grants; pending keeps accumulating when 0
//   req_in       : one-cycle event pulse per requester
//   overflow_clr : clears all sticky overflow bits
//   flag_out     : one-cycle pulse into the crossing channel
//   id_out       : index of the last granted requester, held between grants
//   busy         : high while a grant is being issued or in holdoff
//   pending_out  : registered pending vector
//   overflow     : sticky; an event arrived while its pending bit was set
// -----------------------------------------------------------------------------
module cdc_event_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int HOLDOFF_CYCLES = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_REQ-1:0]  req_in,
    input  logic                overflow_clr,
    output logic                flag_out,
    output logic [ID_WIDTH-1:0] id_out,
    output logic                busy,
    output logic [NUM_REQ-1:0]  pending_out,
    output logic [NUM_REQ-1:0]  overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  flag_q, flag_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0]    pend_q, pend_d;
    logic [NUM_REQ-1:0]    ovf_q, ovf_d;
    logic [7:0]            cnt_q, cnt_d;

    // Round-robin search results
    logic                  hi_vld;
    logic [ID_WIDTH-1:0]   hi_idx;
    logic                  lo_vld;
    logic [ID_WIDTH-1:0]   lo_idx;
    logic [ID_WIDTH-1:0]   win_idx;
    logic                  do_grant;
    logic [NUM_REQ-1:0]    grant_vec;

    // The rotating priority search is split into two parts:
    // - the lowest pending index strictly above last_q (hi), and
    // - the lowest pending index overall (lo), used when nothing lies above last_q.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lo_vld = 1'b1;
                lo_idx = ID_WIDTH'(i);
                if (i > int'(last_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = ID_WIDTH'(i);
                end
            end
        end
    end

    assign win_idx  = hi_vld ? hi_idx : lo_idx;
    assign do_grant = (state_q == ST_IDLE) && enable && lo_vld;

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = do_grant && (win_idx == ID_WIDTH'(i));
        end
    end

    // Pending and overflow. A request that lands on its own grant edge is
    // kept as a fresh event. It is not counted as lost.
    always_comb begin
        pend_d = (pend_q & ~grant_vec) | req_in;
        ovf_d  = (overflow_clr ? '0 : ovf_q) | (req_in & pend_q & ~grant_vec);
    end

    always_comb begin
        state_d = state_q;
        flag_d  = 1'b0;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (do_grant) begin
                    flag_d  = 1'b1;
                    id_d    = win_idx;
                    last_d  = win_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'(HOLDOFF_CYCLES - 1);
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            flag_q  <= 1'b0;
            id_q    <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            pend_q  <= '0;
            ovf_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            id_q    <= id_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flag_out    = flag_q;
    assign id_out      = id_q;
    assign busy        = (state_q != ST_IDLE);
    assign pending_out = pend_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cdc_event_scheduler
//
// Bench for cdc_event_scheduler. It has three parts:
// - Directed scenarios, checked against hand-derived literals.
// - A randomized run, checked every cycle against a behavioural model.
//   The model tracks a pending set, a round-robin pointer and a count of
//   remaining busy cycles.
// - Occasional asynchronous resets mixed into the randomized run.
// -----------------------------------------------------------------------------
module tb_cdc_event_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int HC  = 12;

    logic           clk;
    logic           reset_n;
    logic           enable;
    logic [N-1:0]   req_in;
    logic           overflow_clr;
    logic           flag_out;
    logic [IDW-1:0] id_out;
    logic           busy;
    logic [N-1:0]   pending_out;
    logic [N-1:0]   overflow;

    cdc_event_scheduler #(
        .NUM_REQ        (N),
        .ID_WIDTH       (IDW),
        .HOLDOFF_CYCLES (HC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .req_in       (req_in),
        .overflow_clr (overflow_clr),
        .flag_out     (flag_out),
        .id_out       (id_out),
        .busy         (busy),
        .pending_out  (pending_out),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    int           m_last;
    int           m_id;
    int           m_busy_left;
    logic         m_flag;

    // Last observed outputs, used by the directed scenarios
    logic         obs_flag;
    int           obs_id;
    logic         obs_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pend      = '0;
        m_ovf       = '0;
        m_last      = N - 1;
        m_id        = 0;
        m_busy_left = 0;
        m_flag      = 1'b0;
    endtask

    // One clock edge of the scheduler, described in terms of events and busy time.
    // After a grant, the block is busy for 1 issue cycle plus HC holdoff cycles.
    task automatic model_step(input logic [N-1:0] r, input logic e, input logic c);
        logic [N-1:0] g;
        logic [N-1:0] new_ovf;
        int           w;
        g = '0;
        w = -1;
        if (m_busy_left == 0 && e && m_pend != '0) begin
            for (int off = 1; off <= N; off++) begin
                int idx;
                idx = (m_last + off) % N;
                if (w < 0 && ((m_pend >> idx) & N'(1)) != '0) w = idx;
            end
            g           = N'(1) << w;
            m_flag      = 1'b1;
            m_id        = w;
            m_last      = w;
            m_busy_left = HC + 1;
        end else begin
            m_flag = 1'b0;
            if (m_busy_left > 0) m_busy_left--;
        end
        new_ovf = (c ? '0 : m_ovf) | (r & m_pend & ~g);
        m_pend  = (m_pend & ~g) | r;
        m_ovf   = new_ovf;
    endtask

    task automatic compare_all();
        chk("flag_out", 32'(flag_out), 32'(m_flag));
        chk("id_out", 32'(id_out), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_busy_left > 0));
        chk("pending_out", 32'(pending_out), 32'(m_pend));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called at a negedge: drive, take one edge, sample on the next negedge.
    task automatic cycle(input logic [N-1:0] r, input logic e, input logic c);
        req_in       = r;
        enable       = e;
        overflow_clr = c;
        @(posedge clk);
        model_step(r, e, c);
        @(negedge clk);
        compare_all();
        obs_flag = flag_out;
        obs_id   = int'(id_out);
        obs_busy = busy;
    endtask

    task automatic do_reset();
        req_in       = '0;
        enable       = 1'b1;
        overflow_clr = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        req_in       = '0;
        overflow_clr = 1'b0;
        reset_n      = 1'b1;
    endtask

    initial begin : main
        int t_rise[$];
        int ids[$];
        int cnt;
        int t;

        reset_n      = 1'b0;
        enable       = 1'b0;
        req_in       = '0;
        overflow_clr = 1'b0;
        model_reset();
        #1;
        chk("reset flag_out", 32'(flag_out), 32'd0);
        chk("reset id_out", 32'(id_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset pending", 32'(pending_out), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single event from requester 2
        cycle(4'b0100, 1'b1, 1'b0);
        chk("t1 pending after req", 32'(pending_out), 32'h4);
        chk("t1 no flag yet", 32'(obs_flag), 32'd0);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("t1 flag", 32'(obs_flag), 32'd1);
        chk("t1 id", 32'(obs_id), 32'd2);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0000, 1'b1, 1'b0);
            if (obs_busy) cnt++;
        end
        chk("t1 busy cycles", 32'(cnt), 32'd13);
        chk("t1 pending cleared", 32'(pending_out), 32'd0);

        // All four at once: grants 0,1,2,3, spaced 14 cycles apart
        do_reset();
        cycle(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            cycle(4'b0000, 1'b1, 1'b0);
            if (obs_flag) begin
                t_rise.push_back(i);
                ids.push_back(obs_id);
            end
        end
        chk("t2 grant count", 32'(ids.size()), 32'd4);
        if (ids.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t2 grant order", 32'(ids[k]), 32'(k));
            for (int k = 1; k < 4; k++) chk("t2 flag spacing", 32'(t_rise[k] - t_rise[k-1]), 32'd14);
        end
        chk("t2 no overflow", 32'(overflow), 32'd0);

        // Fairness: each winner re-requests right after its grant
        do_reset();
        ids.delete();
        cycle(4'b1001, 1'b1, 1'b0);
        t = 0;
        while (ids.size() < 4 && t < 100) begin
            cycle(4'b0000, 1'b1, 1'b0);
            if (obs_flag) begin
                ids.push_back(obs_id);
                cycle(N'(1) << obs_id, 1'b1, 1'b0);
            end
            t++;
        end
        chk("t3 grant count", 32'(ids.size()), 32'd4);
        if (ids.size() == 4) begin
            chk("t3 g0", 32'(ids[0]), 32'd0);
            chk("t3 g1", 32'(ids[1]), 32'd3);
            chk("t3 g2", 32'(ids[2]), 32'd0);
            chk("t3 g3", 32'(ids[3]), 32'd3);
        end

        // Overflow set, set-beats-clear, then plain clear
        do_reset();
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        chk("t4 overflow set", 32'(overflow), 32'h2);
        cycle(4'b0010, 1'b1, 1'b1);
        chk("t4 set beats clear", 32'(overflow), 32'h2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0000, 1'b1, 1'b0);
            if (obs_flag && obs_id == 1) cnt++;
        end
        chk("t4 single grant of 1", 32'(cnt), 32'd1);
        cycle(4'b0000, 1'b1, 1'b1);
        chk("t4 overflow cleared", 32'(overflow), 32'h0);

        // Request coinciding with its own grant
        do_reset();
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        chk("t5 flag", 32'(obs_flag), 32'd1);
        chk("t5 id", 32'(obs_id), 32'd2);
        chk("t5 pending kept", 32'(pending_out), 32'h4);
        chk("t5 no overflow", 32'(overflow), 32'h0);
        t = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(4'b0000, 1'b1, 1'b0);
            if (obs_flag && t < 0) t = i;
        end
        chk("t5 second flag delay", 32'(t), 32'd14);
        chk("t5 second id", 32'(obs_id), 32'd2);

        // enable low holds off grants; async reset mid-holdoff
        do_reset();
        cycle(4'b0011, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0000, 1'b0, 1'b0);
            if (obs_flag) cnt++;
        end
        chk("t6 no flag while disabled", 32'(cnt), 32'd0);
        chk("t6 pending held", 32'(pending_out), 32'h3);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("t6 flag after enable", 32'(obs_flag), 32'd1);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b1, 1'b0);
        chk("t6 busy before reset", 32'(busy), 32'd1);
        async_reset();
        chk("t6 busy after reset", 32'(busy), 32'd0);
        chk("t6 pending after reset", 32'(pending_out), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(4'b0000, 1'b1, 1'b0);
            if (obs_flag) cnt++;
        end
        chk("t6 no flag after reset", 32'(cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            logic         e;
            logic         c;
            r = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 31) == 0);
            cycle(r, e, c);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
